effect_sample_sequencer: RTL and testbench
==========================================

// Module: effect_sample_sequencer
// PURPOSE
//  Per-sample scheduler between the input sample FIFO, the distortion effect core and the output sample FIFO.
//  On each audio-rate tick it pops one sample, feeds it to the effect, waits for the result and pushes it out.
//  Replaces ad-hoc FIFO/effect sequencing. Reports underrun/overrun/timeout status to the Avalon register block.
// PARAMETERS
//  DATA_W          32  sample width (input FIFO q, effect in/out, output FIFO data)
//  CNT_W           16  width of each saturating event counter
//  TIMEOUT_CYCLES  64  max clk cycles in WAIT for fx_ready before timeout; must be >= 2
// PORTS
//  clk              in   1       system clock; all logic on posedge
//  reset            in   1       synchronous, active-high reset
//  sample_tick      in   1       one-cycle strobe at audio sample rate
//  enable           in   1       0 = ignore ticks (sequencer idles)
//  cfg_bypass       in   1       requested effect bypass
//  clear_status     in   1       one-cycle pulse: clear counters and sticky flags
//  in_rdempty       in   1       input FIFO empty
//  in_rdreq         out  1       input FIFO pop; q valid on the following cycle
//  in_q             in   DATA_W  input FIFO read data
//  fx_bypass        out  1       bypass to effect core
//  fx_input         out  DATA_W  sample presented to effect core
//  fx_start         out  1       one-cycle strobe: fx_input valid
//  fx_ready         in   1       effect result valid on fx_out (single-cycle pulse)
//  fx_out           in   DATA_W  effect result
//  out_wrfull       in   1       output FIFO full
//  out_wrreq        out  1       output FIFO push
//  out_data         out  DATA_W  output FIFO write data
//  busy             out  1       1 when state != IDLE
//  underrun_cnt     out  CNT_W   ticks with input FIFO empty
//  overrun_cnt      out  CNT_W   results dropped because output FIFO full
//  late_cnt         out  CNT_W   ticks arriving while busy
//  timeout_flag     out  1       sticky: fx_ready not seen within TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; all outputs 0; counters/flags 0; internal last_sample=0.
//  Reset asserted mid-sample abandons it: no in_rdreq/fx_start/out_wrreq in the reset cycle or after.
//  States: IDLE -> READ -> WAIT -> WRITE -> IDLE.
//  IDLE: fx_bypass <= cfg_bypass (updated only here; stable for the whole sample).
//   On sample_tick && enable: if in_rdempty -> underrun_cnt++, stay IDLE; else in_rdreq=1 for 1 cycle, go READ.
//  READ: capture in_q into fx_input and raw register; fx_start=1 for 1 cycle; clear timer; go WAIT.
//  WAIT: on fx_ready: out_data <= fx_out, go WRITE. fx_ready before WAIT is ignored.
//   Timer increments each WAIT cycle; when timer == TIMEOUT_CYCLES-1 with no fx_ready:
//   timeout_flag <= 1, out_data <= raw sample (dry passthrough), go WRITE.
//  WRITE: if !out_wrfull: out_wrreq=1 for 1 cycle, last_sample <= out_data; else overrun_cnt++, drop.
//   Either way go IDLE.
//  Latency: tick -> in_rdreq 1 cycle; fx_ready -> out_wrreq 1 cycle; min tick-to-write 4 + effect latency.
//  sample_tick while busy: late_cnt++, tick discarded (never queued).
//  Counters saturate at all-ones. clear_status wins over a simultaneous increment/set (result 0).
//  enable deasserted mid-sample: current sample completes; later ticks ignored and not counted.
// CONFIGURATION
//  SEQ_HOLD_LAST_EN defined: on an underrun tick, underrun_cnt++ and go to WRITE with out_data = last_sample
//   (repeat previous output; overrun rules apply). Effect core not started.
//  Not defined: underrun tick only increments underrun_cnt; nothing written.
// TESTING
//  Normal: in_q=0x00001234, fx_ready 5 cycles after fx_start with fx_out=0x00002468
//   -> one out_wrreq with out_data=0x00002468; counters 0.
//  Underrun: in_rdempty=1, 3 ticks -> underrun_cnt=3, no in_rdreq;
//   with SEQ_HOLD_LAST_EN, 3 writes of last_sample.
//  Timeout: TIMEOUT_CYCLES=64, fx_ready never asserted, in_q=0x0000ABCD
//   -> out_wrreq 64 cycles after fx_start, out_data=0x0000ABCD, timeout_flag=1.
//  Overrun + late: out_wrfull=1 during WRITE -> overrun_cnt=1, no out_wrreq;
//   tick during WAIT -> late_cnt=1.
//  Saturation/clear: force CNT_W=4, 20 underruns -> underrun_cnt=15;
//   clear_status coincident with tick -> 0.
//  Reset in WAIT: assert reset 1 cycle -> next cycle busy=0, all outputs 0, no out_wrreq ever for that sample.

Source files
------------

// File: rtl/effect_sample_sequencer.sv
// effect_sample_sequencer: on each audio tick pops one input sample, runs it through the effect core and pushes the result.
// Build option SEQ_HOLD_LAST_EN: an underrun tick re-writes the last pushed sample instead of writing nothing.
module effect_sample_sequencer #(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              enable,
    input  logic              cfg_bypass,
    input  logic              clear_status,
    input  logic              in_rdempty,
    output logic              in_rdreq,
    input  logic [DATA_W-1:0] in_q,
    output logic              fx_bypass,
    output logic [DATA_W-1:0] fx_input,
    output logic              fx_start,
    input  logic              fx_ready,
    input  logic [DATA_W-1:0] fx_out,
    input  logic              out_wrfull,
    output logic              out_wrreq,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic [CNT_W-1:0]  late_cnt,
    output logic              timeout_flag,
    output logic [1:0]        dbg_state
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              rd_phase_q, rd_phase_d;
    logic              start_q, start_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              fx_bypass_q, fx_bypass_d;
    logic [DATA_W-1:0] fx_input_q, fx_input_d;
    logic [DATA_W-1:0] raw_q, raw_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] last_sample_q, last_sample_d;
    logic [CNT_W-1:0]  underrun_q, underrun_d;
    logic [CNT_W-1:0]  overrun_q, overrun_d;
    logic [CNT_W-1:0]  late_q, late_d;
    logic              timeout_q, timeout_d;

    logic tick_en;
    logic underrun_inc;
    logic overrun_inc;
    logic late_inc;
    logic timeout_set;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                   input logic             inc,
                                                   input logic             clr);
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != CNT_MAX)) begin
            nxt = cur + CNT_W'(1);
        end
        return nxt;
    endfunction

    always_comb begin
        state_d       = state_q;
        rd_phase_d    = rd_phase_q;
        start_d       = 1'b0;
        timer_d       = timer_q;
        fx_bypass_d   = fx_bypass_q;
        fx_input_d    = fx_input_q;
        raw_d         = raw_q;
        out_data_d    = out_data_q;
        last_sample_d = last_sample_q;
        underrun_inc  = 1'b0;
        overrun_inc   = 1'b0;
        timeout_set   = 1'b0;
        tick_en       = sample_tick && enable;
        late_inc      = tick_en && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                fx_bypass_d = cfg_bypass;
                if (tick_en) begin
                    if (in_rdempty) begin
                        underrun_inc = 1'b1;
`ifdef SEQ_HOLD_LAST_EN
                        out_data_d = last_sample_q;
                        state_d    = ST_WRITE;
`else
                        state_d    = ST_IDLE;
`endif
                    end else begin
                        rd_phase_d = 1'b0;
                        state_d    = ST_READ;
                    end
                end
            end
            // READ spans two cycles: the pop request, then the cycle in_q carries the popped word.
            ST_READ: begin
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d = 1'b0;
                    fx_input_d = in_q;
                    raw_d      = in_q;
                    start_d    = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fx_ready) begin
                    out_data_d = fx_out;
                    state_d    = ST_WRITE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_set = 1'b1;
                    out_data_d  = raw_q;
                    state_d     = ST_WRITE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WRITE: begin
                if (!out_wrfull) begin
                    last_sample_d = out_data_q;
                end else begin
                    overrun_inc = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        underrun_d = cnt_next(underrun_q, underrun_inc, clear_status);
        overrun_d  = cnt_next(overrun_q, overrun_inc, clear_status);
        late_d     = cnt_next(late_q, late_inc, clear_status);
        timeout_d  = clear_status ? 1'b0 : (timeout_q | timeout_set);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rd_phase_q    <= 1'b0;
            start_q       <= 1'b0;
            timer_q       <= '0;
            fx_bypass_q   <= 1'b0;
            fx_input_q    <= '0;
            raw_q         <= '0;
            out_data_q    <= '0;
            last_sample_q <= '0;
            underrun_q    <= '0;
            overrun_q     <= '0;
            late_q        <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_phase_q    <= rd_phase_d;
            start_q       <= start_d;
            timer_q       <= timer_d;
            fx_bypass_q   <= fx_bypass_d;
            fx_input_q    <= fx_input_d;
            raw_q         <= raw_d;
            out_data_q    <= out_data_d;
            last_sample_q <= last_sample_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
            late_q        <= late_d;
            timeout_q     <= timeout_d;
        end
    end

    // Strobes are single-cycle, active-high, no back-pressure; they are masked while reset is
    // held so a sample abandoned by reset never pops, starts or pushes in the reset cycle.
    assign in_rdreq     = !reset && (state_q == ST_READ) && !rd_phase_q;
    assign fx_start     = !reset && start_q;
    assign out_wrreq    = !reset && (state_q == ST_WRITE) && !out_wrfull;
    assign fx_bypass    = fx_bypass_q;
    assign fx_input     = fx_input_q;
    assign out_data     = out_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign underrun_cnt = underrun_q;
    assign overrun_cnt  = overrun_q;
    assign late_cnt     = late_q;
    assign timeout_flag = timeout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_effect_sample_sequencer.sv
// Directed testbench for effect_sample_sequencer with a write scoreboard and a non-showahead FIFO model.
module tb_effect_sample_sequencer;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int TO     = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_tick;
  logic              enable;
  logic              cfg_bypass;
  logic              clear_status;
  logic              in_rdempty;
  logic              in_rdreq;
  logic [DATA_W-1:0] in_q;
  logic              fx_bypass;
  logic [DATA_W-1:0] fx_input;
  logic              fx_start;
  logic              fx_ready;
  logic [DATA_W-1:0] fx_out;
  logic              out_wrfull;
  logic              out_wrreq;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic [CNT_W-1:0]  underrun_cnt;
  logic [CNT_W-1:0]  overrun_cnt;
  logic [CNT_W-1:0]  late_cnt;
  logic              timeout_flag;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] next_q;
  logic [DATA_W-1:0] last_model;

  effect_sample_sequencer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .enable(enable),
    .cfg_bypass(cfg_bypass), .clear_status(clear_status), .in_rdempty(in_rdempty),
    .in_rdreq(in_rdreq), .in_q(in_q), .fx_bypass(fx_bypass), .fx_input(fx_input),
    .fx_start(fx_start), .fx_ready(fx_ready), .fx_out(fx_out), .out_wrfull(out_wrfull),
    .out_wrreq(out_wrreq), .out_data(out_data), .busy(busy), .underrun_cnt(underrun_cnt),
    .overrun_cnt(overrun_cnt), .late_cnt(late_cnt), .timeout_flag(timeout_flag),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // non-showahead input FIFO: the popped word appears on in_q after the pop edge
  always @(posedge clk) begin
    if (reset) in_q <= 32'hDEAD_0000;
    else if (in_rdreq) in_q <= next_q;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every output FIFO push is matched against the oldest expected sample
  always @(negedge clk) begin
    if (in_rdreq === 1'b1) rd_cnt++;
    if (out_wrreq === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", out_data, 32'hFFFF_FFFF ^ out_data);
      end else begin
        check("write_data", out_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (fx_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("fx_start_seen", fx_start, 1);
  endtask

  initial begin
    int n;
    int rd0;
    int wr0;
    reset = 1'b1; sample_tick = 0; enable = 1; cfg_bypass = 0; clear_status = 0;
    in_rdempty = 1; fx_ready = 0; fx_out = '0; out_wrfull = 0; next_q = '0;
    last_model = '0;
    cyc(3);
    check("rst_busy", busy, 0);
    check("rst_rdreq", in_rdreq, 0);
    check("rst_wrreq", out_wrreq, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_fx_start", fx_start, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fx_input", fx_input, 0);
    check("rst_counters", {underrun_cnt, overrun_cnt, late_cnt}, 0);
    check("rst_timeout", timeout_flag, 0);

    // normal sample, with an early fx_ready during READ that must be ignored
    rd0 = rd_cnt;
    cfg_bypass = 1; in_rdempty = 0; next_q = 32'h0000_1234;
    pulse_tick();
    check("rdreq_latency", in_rdreq, 1);
    fx_ready = 1; fx_out = 32'h0000_DEAD;
    @(negedge clk);
    fx_ready = 0;
    check("rdreq_one_cycle", in_rdreq, 0);
    @(negedge clk);
    check("fx_start_latency", fx_start, 1);
    check("fx_input_normal", fx_input, 32'h0000_1234);
    check("fx_bypass_latched", fx_bypass, 1);
    check("busy_in_wait", busy, 1);
    cfg_bypass = 0;
    cyc(5);
    fx_ready = 1; fx_out = 32'h0000_2468;
    exp_q.push_back(32'h0000_2468);
    @(negedge clk);
    fx_ready = 0;
    check("fx_bypass_stable", fx_bypass, 1);
    check("wrreq_latency", out_wrreq, 1);
    last_model = 32'h0000_2468;
    @(negedge clk);
    check("idle_after_write", busy, 0);
    check("normal_counters", {underrun_cnt, overrun_cnt, late_cnt}, 0);
    check("normal_one_pop", rd_cnt - rd0, 1);

    // underrun: three ticks with the input FIFO empty
    rd0 = rd_cnt; wr0 = wr_cnt; in_rdempty = 1;
    for (int i = 0; i < 3; i++) begin
`ifdef SEQ_HOLD_LAST_EN
      exp_q.push_back(last_model);
`endif
      pulse_tick();
      cyc(2);
    end
    check("underrun_cnt_3", underrun_cnt, 3);
    check("underrun_no_pop", rd_cnt - rd0, 0);
`ifdef SEQ_HOLD_LAST_EN
    check("underrun_writes", wr_cnt - wr0, 3);
`else
    check("underrun_writes", wr_cnt - wr0, 0);
`endif

    // timeout: fx_ready never comes, raw sample passes through
    in_rdempty = 0; next_q = 32'h0000_ABCD;
    pulse_tick();
    wait_start(10);
    check("timeout_fx_input", fx_input, 32'h0000_ABCD);
    exp_q.push_back(32'h0000_ABCD);
    n = 0;
    while (out_wrreq !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TO);
    check("timeout_flag_set", timeout_flag, 1);
    check("fx_bypass_relatched", fx_bypass, 0);
    last_model = 32'h0000_ABCD;
    @(negedge clk);

    // overrun with a late tick during WAIT
    wr0 = wr_cnt; next_q = 32'h5555_0000;
    pulse_tick();
    wait_start(10);
    sample_tick = 1; out_wrfull = 1;
    @(negedge clk);
    sample_tick = 0; fx_ready = 1; fx_out = 32'h0000_1111;
    @(negedge clk);
    fx_ready = 0;
    check("overrun_no_wrreq", out_wrreq, 0);
    @(negedge clk);
    out_wrfull = 0;
    check("overrun_cnt_1", overrun_cnt, 1);
    check("late_cnt_1", late_cnt, 1);
    check("overrun_dropped", wr_cnt - wr0, 0);

    // clear, then saturation of a 4-bit counter
    clear_status = 1;
    @(negedge clk);
    clear_status = 0;
    check("clear_counters", {underrun_cnt, overrun_cnt, late_cnt}, 0);
    check("clear_timeout", timeout_flag, 0);
    in_rdempty = 1;
    for (int i = 0; i < 20; i++) begin
`ifdef SEQ_HOLD_LAST_EN
      exp_q.push_back(last_model);
`endif
      pulse_tick();
      cyc(2);
    end
    check("underrun_saturated", underrun_cnt, 15);
`ifdef SEQ_HOLD_LAST_EN
    exp_q.push_back(last_model);
`endif
    sample_tick = 1; clear_status = 1;
    @(negedge clk);
    sample_tick = 0; clear_status = 0;
    cyc(2);
    check("clear_beats_inc", underrun_cnt, 0);

    // enable dropped mid-sample: sample completes, disabled ticks are not counted
    in_rdempty = 0; next_q = 32'h0BAD_F00D;
    pulse_tick();
    wait_start(10);
    check("en_fx_input", fx_input, 32'h0BAD_F00D);
    enable = 0; sample_tick = 1;
    @(negedge clk);
    sample_tick = 0; fx_ready = 1; fx_out = 32'h0000_7777;
    exp_q.push_back(32'h0000_7777);
    @(negedge clk);
    fx_ready = 0;
    check("en_sample_completes", out_wrreq, 1);
    last_model = 32'h0000_7777;
    @(negedge clk);
    check("disabled_no_late", late_cnt, 0);
    rd0 = rd_cnt;
    pulse_tick();
    in_rdempty = 1;
    pulse_tick();
    cyc(3);
    check("disabled_no_pop", rd_cnt - rd0, 0);
    check("disabled_no_underrun", underrun_cnt, 0);

    // reset while waiting on the effect abandons the sample
    enable = 1; cfg_bypass = 1; in_rdempty = 0; next_q = 32'h0000_0042;
    pulse_tick();
    wait_start(10);
    wr0 = wr_cnt;
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst_wait_busy", busy, 0);
    check("rst_wait_strobes", {in_rdreq, fx_start, out_wrreq}, 0);
    check("rst_wait_fx_input", fx_input, 0);
    check("rst_wait_out_data", out_data, 0);
    check("rst_wait_bypass", fx_bypass, 0);
    fx_ready = 1; fx_out = 32'h0000_0099;
    @(negedge clk);
    fx_ready = 0;
    cyc(10);
    check("rst_wait_no_write", wr_cnt - wr0, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
